// File: rtl/noisy_sine_source.sv
// Table-driven sine generator with Galois-LFSR noise and saturating output,
// streamed over a valid/ready handshake with a one-deep prefetch stage.
module noisy_sine_source #(
  parameter int          DATA_W     = 16,
  parameter int          TABLE_LEN  = 100,
  parameter int          STEP       = 25,
  parameter int          NOISE_BITS = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     noise_en,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] noisy_signal
);

  localparam int  IDX_W = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  // One full period, evaluated entirely at elaboration time.
  logic signed [DATA_W-1:0] sine_rom [TABLE_LEN];
  generate
    for (genvar gi = 0; gi < TABLE_LEN; gi++) begin : g_rom
      localparam int ENTRY = $rtoi(32767.0 * $sin(2.0 * PI * gi / TABLE_LEN));
      assign sine_rom[gi] = DATA_W'(ENTRY);
    end
  endgenerate

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic signed [DATA_W-1:0] sine_q, sine_d;
  logic signed [DATA_W-1:0] noise_q, noise_d;
  logic                     primed_q, primed_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] noisy_q, noisy_d;

  logic [IDX_W:0]             idx_sum;
  logic [IDX_W-1:0]           idx_next;
  logic [15:0]                lfsr_next;
  logic signed [NOISE_BITS-1:0] noise_raw;
  logic signed [DATA_W-1:0]   noise_ext;
  logic signed [DATA_W:0]     sum_w;
  logic signed [DATA_W-1:0]   sat_value;
  logic                       fetch;
  logic                       load;

  always_comb begin
    idx_sum = {1'b0, idx_q} + (IDX_W+1)'(STEP);
    if (idx_sum >= (IDX_W+1)'(TABLE_LEN)) begin
      idx_next = IDX_W'(idx_sum - (IDX_W+1)'(TABLE_LEN));
    end else begin
      idx_next = IDX_W'(idx_sum);
    end
  end

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign noise_raw = lfsr_q[NOISE_BITS-1:0];
  assign noise_ext = DATA_W'(noise_raw);

  // One guard bit is enough: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sum_w = (DATA_W+1)'(sine_q) + (DATA_W+1)'(noise_q);
    if (sum_w[DATA_W] != sum_w[DATA_W-1]) begin
      sat_value = sum_w[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_value = sum_w[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    sine_d      = sine_q;
    noise_d     = noise_q;
    primed_d    = primed_q;
    out_valid_d = out_valid_q;
    noisy_d     = noisy_q;
    fetch       = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (primed_q) begin
            load        = 1'b1;
            fetch       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = STREAM;
          end else begin
            state_d = PRIME;
          end
        end
      end
      PRIME: begin
        fetch    = 1'b1;
        primed_d = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        // First cycle after PRIME: the output register is still empty.
        if (!out_valid_q) begin
          load        = 1'b1;
          fetch       = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (enable) begin
            load  = 1'b1;
            fetch = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      sine_d  = sine_rom[idx_q];
      noise_d = noise_en ? noise_ext : '0;
      idx_d   = idx_next;
      lfsr_d  = lfsr_next;
    end
    if (load) begin
      noisy_d = sat_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lfsr_q      <= SEED;
      sine_q      <= '0;
      noise_q     <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      noisy_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      sine_q      <= sine_d;
      noise_q     <= noise_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      noisy_q     <= noisy_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign noisy_signal = noisy_q;

endmodule

// File: tb/tb_noisy_sine_source.sv
// Scoreboard bench: a sample-index reference model fills expected queues,
// independent monitors pop and compare on every accepted handshake.
module tb_noisy_sine_source;

  localparam int  DATA_W    = 16;
  localparam int  TABLE_LEN = 100;
  localparam int  STEP      = 25;
  localparam real PI        = 3.141592653589793;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, noise_en, out_ready, out_valid;
  logic signed [DATA_W-1:0] noisy_signal;
  logic enable_s, noise_en_s, ready_s, valid_s;
  logic signed [DATA_W-1:0] noisy_s;

  noisy_sine_source #(
    .DATA_W(DATA_W), .TABLE_LEN(TABLE_LEN), .STEP(STEP), .NOISE_BITS(10), .SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .noise_en(noise_en), .out_ready(out_ready),
    .out_valid(out_valid), .noisy_signal(noisy_signal)
  );

  noisy_sine_source #(
    .DATA_W(DATA_W), .TABLE_LEN(TABLE_LEN), .STEP(STEP), .NOISE_BITS(16), .SEED(16'hACE1)
  ) u_sat (
    .clk(clk), .rst(rst), .enable(enable_s), .noise_en(noise_en_s), .out_ready(ready_s),
    .out_valid(valid_s), .noisy_signal(noisy_s)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_s[$];
  int clamp_s[$];
  int acc_log[$];
  int acc_cnt   = 0;
  int acc_s_cnt = 0;
  int hi_hits   = 0;
  int lo_hits   = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // Sample n = sat(trunc(32767*sin(2*pi*k/TABLE_LEN)) + noise_n), k = n*STEP mod TABLE_LEN.
  task automatic push_model(input int nb, input bit noise_on, input int count, input bit to_sat);
    int lfsr;
    int k;
    lfsr = 'hACE1;
    k    = 0;
    for (int n = 0; n < count; n++) begin
      int sine;
      int noise;
      int s;
      int clamp;
      sine  = $rtoi(32767.0 * $sin(2.0 * PI * k / TABLE_LEN));
      noise = 0;
      if (noise_on) begin
        noise = lfsr & ((1 << nb) - 1);
        if (noise >= (1 << (nb - 1))) noise -= (1 << nb);
      end
      s     = sine + noise;
      clamp = 0;
      if (s > 32767) begin s = 32767; clamp = 1; end
      if (s < -32768) begin s = -32768; clamp = -1; end
      if (to_sat) begin
        exp_s.push_back(s);
        clamp_s.push_back(clamp);
      end else begin
        exp_q.push_back(s);
      end
      k    = (k + STEP) % TABLE_LEN;
      lfsr = (lfsr & 1) ? ((lfsr >> 1) ^ 'hB400) : (lfsr >> 1);
    end
  endtask

  // Monitor for the main instance: scoreboard pop plus stall-stability.
  initial begin
    bit prev_stall;
    int prev_data;
    int e;
    prev_stall = 1'b0;
    prev_data  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(noisy_signal), prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sample: got %0d required no sample", noisy_signal);
          end else begin
            e = exp_q.pop_front();
            check("sample", int'(noisy_signal), e);
          end
          $display("txn main %0d sample=%0d", acc_cnt, noisy_signal);
          acc_log.push_back(int'(noisy_signal));
          acc_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = int'(noisy_signal);
      end
    end
  end

  // Monitor for the wide-noise instance: range, exact value, rail hits.
  initial begin
    int e;
    int c;
    forever begin
      @(negedge clk);
      if (!rst && valid_s && ready_s) begin
        check("sat_range", int'(noisy_s >= -32768 && noisy_s <= 32767), 1);
        if (exp_s.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sat_unexpected: got %0d required no sample", noisy_s);
        end else begin
          e = exp_s.pop_front();
          c = clamp_s.pop_front();
          check("sat_sample", int'(noisy_s), e);
          if (c == 1 && noisy_s == 16'sd32767) hi_hits++;
          if (c == -1 && noisy_s == -16'sd32768) lo_hits++;
        end
        $display("txn sat %0d sample=%0d", acc_s_cnt, noisy_s);
        acc_s_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; enable_s = 1'b0; ready_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); acc_log.delete(); acc_cnt = 0;
    exp_s.delete(); clamp_s.delete(); acc_s_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input string name, input int target, input int budget, input bit sat);
    int n;
    n = 0;
    while (((sat ? acc_s_cnt : acc_cnt) < target) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((sat ? acc_s_cnt : acc_cnt) < target) begin
      failures++;
      $display("FAIL %s: got %0d accepted required %0d", name, sat ? acc_s_cnt : acc_cnt, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; noise_en = 1'b0; out_ready = 1'b0;
    enable_s = 1'b0; noise_en_s = 1'b1; ready_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(noisy_signal), 0);
    check("reset_sat_valid", int'(valid_s), 0);

    // Clean sine, latency, idx wrap over 200 samples.
    do_reset();
    noise_en = 1'b0;
    push_model(10, 1'b0, 208, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("latency_one_edge", int'(out_valid), 0);
    @(negedge clk);
    check("latency_two_edges", int'(out_valid), 1);
    wait_cnt("clean_count", 200, 400, 1'b0);
    if (acc_log.size() >= 4) begin
      check("clean_first", acc_log[0], 0);
      check("clean_second", acc_log[1], 32767);
      check("clean_fourth", acc_log[3], -32767);
    end

    // Noisy stream, 1000 samples.
    do_reset();
    noise_en = 1'b1;
    push_model(10, 1'b1, 1008, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1; out_ready = 1'b1;
    wait_cnt("noisy_count", 1000, 1200, 1'b0);
    if (acc_log.size() >= 2) begin
      check("noisy_first", acc_log[0], 225);
      check("noisy_second", acc_log[1], 32367);
    end

    // Random backpressure.
    do_reset();
    push_model(10, 1'b1, 308, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1;
    for (int n = 0; n < 1500 && acc_cnt < 300; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_cnt("backpressure_count", 300, 20, 1'b0);

    // Pause and resume.
    do_reset();
    push_model(10, 1'b1, 88, 1'b0);
    @(posedge clk); #1;
    enable = 1'b1; out_ready = 1'b1;
    wait_cnt("pause_pre_count", 20, 100, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pause_held_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("pause_accept_valid", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("pause_idle_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk); @(negedge clk);
    check("resume_valid", int'(out_valid), 1);
    wait_cnt("resume_count", 80, 200, 1'b0);

    // Reset mid-stream, with enable still high.
    @(posedge clk); #1;
    check("pre_reset_valid", int'(out_valid), 1);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("midreset_valid", int'(out_valid), 0);
    check("midreset_data", int'(noisy_signal), 0);
    exp_q.delete(); acc_log.delete(); acc_cnt = 0;
    push_model(10, 1'b1, 48, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    wait_cnt("restart_count", 40, 100, 1'b0);
    if (acc_log.size() >= 1) check("restart_first", acc_log[0], 225);

    // Wide noise saturation on the second instance.
    do_reset();
    push_model(16, 1'b1, 1008, 1'b1);
    @(posedge clk); #1;
    enable_s = 1'b1; ready_s = 1'b1;
    wait_cnt("sat_count", 1000, 1200, 1'b1);
    check("sat_hi_rail_hit", int'(hi_hits > 0), 1);
    check("sat_lo_rail_hit", int'(lo_hits > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
